// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with 16x oversampling and a header-framed 24-bit word assembler.
// A frame is a 0x00 header followed by three payload bytes, least-significant byte first.
module uart_rx_frame #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rs232_rx,
  output logic [23:0] recv_data,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned DIV     = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DivW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitClks = DIV * 16;
  localparam int unsigned BitW    = (BitClks > 1) ? $clog2(BitClks) : 1;
  localparam int unsigned ToW     = $clog2(TIMEOUT_BITS + 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {WaitHdr, GetB1, GetB2, GetB3} frame_state_e;

  // Input synchroniser and falling-edge detect
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rs232_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // Oversampling tick generator, parked at zero while idle so each byte starts phase-aligned
  rx_state_e       rx_state;
  logic [DivW-1:0] div_cnt;
  logic            tick;

  assign tick = (rx_state != RxIdle) && (div_cnt == DivW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (rx_state == RxIdle || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Byte receiver
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [1:0] samp;
  logic [7:0] shift;
  logic       maj;
  logic       byte_ok;
  logic       byte_bad;

  // Majority of the tick-7 and tick-8 samples with the live tick-9 value
  assign maj = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RxIdle;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      samp     <= '0;
      shift    <= '0;
      byte_ok  <= 1'b0;
      byte_bad <= 1'b0;
    end else begin
      byte_ok  <= 1'b0;
      byte_bad <= 1'b0;
      case (rx_state)
        RxIdle: begin
          if (rx_fall) begin
            rx_state <= RxStart;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        default: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd7) samp[0] <= rx_sync;
            if (tick_cnt == 4'd8) samp[1] <= rx_sync;
            if (tick_cnt == 4'd9) begin
              case (rx_state)
                RxStart: if (maj) rx_state <= RxIdle;
                RxData:  shift <= {maj, shift[7:1]};
                RxStop: begin
                  // Leave early so a back-to-back start edge is never missed
                  byte_ok  <= maj;
                  byte_bad <= ~maj;
                  rx_state <= RxIdle;
                end
                default: ;
              endcase
            end
            if (tick_cnt == 4'd15) begin
              if (rx_state == RxStart) begin
                rx_state <= RxData;
              end else if (rx_state == RxData) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) rx_state <= RxStop;
              end
            end
          end
        end
      endcase
    end
  end

  // Frame assembler with inter-byte timeout
  frame_state_e    frame_state;
  logic [15:0]     staging;
  logic [BitW-1:0] to_clk;
  logic [ToW-1:0]  to_bits;
  logic            to_bit_wrap;

  assign to_bit_wrap = (frame_state != WaitHdr) && (rx_state == RxIdle) &&
                       (to_clk == BitW'(BitClks - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_state <= WaitHdr;
      staging     <= '0;
      recv_data   <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      to_clk      <= '0;
      to_bits     <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (frame_state == WaitHdr || byte_ok) begin
        to_clk  <= '0;
        to_bits <= '0;
      end else if (rx_state == RxIdle) begin
        if (to_bit_wrap) begin
          to_clk  <= '0;
          to_bits <= to_bits + 1'b1;
        end else begin
          to_clk <= to_clk + 1'b1;
        end
      end

      if (byte_bad) begin
        frame_err   <= 1'b1;
        frame_state <= WaitHdr;
        busy        <= 1'b0;
      end else if (byte_ok) begin
        case (frame_state)
          WaitHdr: begin
            if (shift == 8'h00) begin
              frame_state <= GetB1;
              busy        <= 1'b1;
            end
          end
          GetB1: begin
            staging[7:0] <= shift;
            frame_state  <= GetB2;
          end
          GetB2: begin
            staging[15:8] <= shift;
            frame_state   <= GetB3;
          end
          GetB3: begin
            recv_data   <= {shift, staging};
            data_valid  <= 1'b1;
            frame_state <= WaitHdr;
            busy        <= 1'b0;
          end
          default: frame_state <= WaitHdr;
        endcase
      end else if (to_bit_wrap && to_bits == ToW'(TIMEOUT_BITS - 1)) begin
        frame_err   <= 1'b1;
        frame_state <= WaitHdr;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames, header hunting, zero payload, timeout,
// stop-bit error, glitch rejection and mid-frame reset.
module tb_uart_rx_frame;

  localparam int unsigned CLK_FREQ = 1_300_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int          BIT      = 130;  // CLK_FREQ / BAUD clocks per serial bit

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rs232_rx = 1'b1;
  logic [23:0] recv_data;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  uart_rx_frame #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rs232_rx  (rs232_rx),
    .recv_data (recv_data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Free-running cycle count and output monitor
  int          cyc = 0;
  int          dv_cnt = 0;
  int          fe_cnt = 0;
  int          both_cnt = 0;
  int          dv_long = 0;
  int          rd_bad = 0;
  int          dv_cyc = 0;
  int          fe_cyc = 0;
  logic        dv_prev = 1'b0;
  logic [23:0] rd_prev = 24'h0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
    end
    if (frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (data_valid && frame_err) both_cnt++;
    if (data_valid && dv_prev) dv_long++;
    if (rst && !data_valid && recv_data !== rd_prev) rd_bad++;
    dv_prev = data_valid;
    rd_prev = recv_data;
  end

  int last_start = 0;

  // Sends the first nsym symbols of {stop, data, start}, LSB first
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int nsym);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    last_start = cyc;
    for (int i = 0; i < nsym; i++) begin
      rs232_rx = frame[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1, 10);
  endtask

  task automatic idle_bits(input int n);
    rs232_rx = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_recv_data"}, {8'h0, recv_data}, 32'h0);
    check({tag, "_data_valid"}, {31'h0, data_valid}, 32'h0);
    check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int dv0, fe0, s3, s44, delta;

  initial begin
    repeat (5) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    idle_bits(2);

    // Back-to-back frame
    dv0 = dv_cnt; fe0 = fe_cnt;
    send(8'h00);
    check("t1_busy_after_hdr", {31'h0, busy}, 32'h1);
    send(8'h11);
    send(8'h22);
    s3 = cyc;
    send(8'h33);
    idle_bits(2);
    check("t1_dv_count", dv_cnt - dv0, 1);
    check("t1_fe_count", fe_cnt - fe0, 0);
    check("t1_recv_data", {8'h0, recv_data}, 32'h332211);
    check("t1_busy_idle", {31'h0, busy}, 32'h0);
    delta = dv_cyc - s3;
    check("t1_dv_in_stop_bit", 32'(delta >= 9 * BIT && delta < 10 * BIT), 32'h1);

    // Non-header bytes are discarded
    dv0 = dv_cnt; fe0 = fe_cnt;
    send(8'hAA);
    send(8'h55);
    check("t2_busy_after_junk", {31'h0, busy}, 32'h0);
    send(8'h00); send(8'h01); send(8'h02); send(8'h03);
    idle_bits(2);
    check("t2_dv_count", dv_cnt - dv0, 1);
    check("t2_fe_count", fe_cnt - fe0, 0);
    check("t2_recv_data", {8'h0, recv_data}, 32'h030201);

    // Zero payload
    dv0 = dv_cnt;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    idle_bits(2);
    check("t3_dv_count", dv_cnt - dv0, 1);
    check("t3_recv_data", {8'h0, recv_data}, 32'h000000);

    // Inter-byte timeout
    dv0 = dv_cnt; fe0 = fe_cnt;
    send(8'h00);
    s44 = cyc;
    send(8'h44);
    idle_bits(25);
    check("t4_fe_count", fe_cnt - fe0, 1);
    check("t4_dv_count", dv_cnt - dv0, 0);
    delta = fe_cyc - s44;
    check("t4_fe_near_20_bits", 32'(delta >= 27 * BIT + BIT / 2 && delta <= 31 * BIT), 32'h1);
    check("t4_busy", {31'h0, busy}, 32'h0);
    send(8'h00); send(8'h77); send(8'h88); send(8'h99);
    idle_bits(2);
    check("t4_dv_after", dv_cnt - dv0, 1);
    check("t4_recv_data", {8'h0, recv_data}, 32'h998877);

    // Stop-bit error aborts the frame
    dv0 = dv_cnt; fe0 = fe_cnt;
    send(8'h00);
    send(8'h12);
    send_byte(8'h5A, 1'b0, 10);
    idle_bits(1);
    send(8'h34);
    send(8'h56);
    idle_bits(2);
    check("t5_fe_count", fe_cnt - fe0, 1);
    check("t5_dv_count", dv_cnt - dv0, 0);
    check("t5_recv_data", {8'h0, recv_data}, 32'h998877);
    check("t5_busy", {31'h0, busy}, 32'h0);

    // Short glitch on an idle line
    dv0 = dv_cnt; fe0 = fe_cnt;
    rs232_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle_bits(3);
    check("t6_glitch_dv", dv_cnt - dv0, 0);
    check("t6_glitch_fe", fe_cnt - fe0, 0);
    check("t6_glitch_data", {8'h0, recv_data}, 32'h998877);
    check("t6_glitch_busy", {31'h0, busy}, 32'h0);

    // Reset in the middle of a payload byte
    send(8'h00);
    send(8'hAB);
    send_byte(8'hCD, 1'b1, 5);
    repeat (BIT / 2) @(negedge clk);
    #3 rst = 1'b0;
    rs232_rx = 1'b1;
    #1;
    check_zero("t6_in_reset");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    idle_bits(2);
    check_zero("t6_after_reset");
    check("t6_rst_dv", dv_cnt - dv0, 0);
    check("t6_rst_fe", fe_cnt - fe0, 0);
    send(8'h00); send(8'h10); send(8'h20); send(8'h30);
    idle_bits(2);
    check("t6_next_dv", dv_cnt - dv0, 1);
    check("t6_next_data", {8'h0, recv_data}, 32'h302010);

    check("pulse_overlap", both_cnt, 0);
    check("dv_width", dv_long, 0);
    check("recv_data_stable", rd_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Receive-side counterpart of the 4-byte UART frame link: a 0x00 header byte followed by three payload bytes, least-significant byte first. The block deserialises 8N1 bytes from `rs232_rx` using 16x oversampling and reassembles them into a 24-bit word. It reports each completed frame with a one-cycle `data_valid` pulse. It sits at the FPGA pin boundary and feeds the 24-bit word to downstream logic.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s
- `TIMEOUT_BITS`, 20, bit periods of idle allowed between bytes inside a frame before the frame is aborted
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `rs232_rx`  in  1  asynchronous serial line, idle high
- `recv_data`  out  24  last complete payload; `{byte3, byte2, byte1}`
- `data_valid`  out  1  one-cycle pulse; `recv_data` is updated in the same cycle
- `frame_err`  out  1  one-cycle pulse on a stop-bit error or an inter-byte timeout
- `busy`  out  1  high while the frame FSM is outside WAIT_HDR

## Operation
- Input synchroniser: 2 flops, both reset to 1. All logic uses the synchronised signal.
- Tick generator: `DIV = CLK_FREQ/(BAUD*16)`, integer truncation (27 at the defaults). Counter runs 0..DIV-1 and emits one tick at wrap. The counter is held at 0 while the byte receiver is idle.
- Byte receiver states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised falling edge.
  - Each bit spans 16 ticks. Samples are taken at ticks 7, 8 and 9 of the bit, and the bit value is the majority of the three.
  - START: a majority of 1 is a glitch; return to IDLE with no error.
  - DATA: 8 bits, LSB first, shifted into a byte register.
  - STOP: the decision is made after the tick-9 sample. Majority 1 means the byte is good and an internal `byte_ok` pulse fires. Majority 0 means a framing error and an internal `byte_bad` pulse fires. Either way return to IDLE immediately, without waiting for the end of the stop bit.
- Frame FSM states: WAIT_HDR, GET_B1, GET_B2, GET_B3.
  - WAIT_HDR: on `byte_ok` with value 0x00 → GET_B1. Any nonzero byte is discarded.
  - GET_B1 captures the byte into the `[7:0]` staging register, GET_B2 into `[15:8]`, GET_B3 into `[23:16]`.
  - On `byte_ok` in GET_B3: copy the staging register with the new byte to `recv_data`, pulse `data_valid`, → WAIT_HDR.
  - Payload bytes equal to 0x00 are accepted as data; a 0x00 is treated as a header only in WAIT_HDR.
  - On `byte_bad` in any state: pulse `frame_err` and → WAIT_HDR. Staging is discarded and `recv_data` is unchanged.
  - Inter-byte timeout (GET_Bx only):
    - Counts bit periods (16 ticks each) while the byte receiver is IDLE.
    - Cleared on every `byte_ok`.
    - On reaching `TIMEOUT_BITS`: pulse `frame_err` and → WAIT_HDR.
    - Disabled and held at 0 in WAIT_HDR.
- `recv_data` holds its value until the next valid frame.

## Timing
- Reset values:
  - `recv_data` = 0, `data_valid` = 0, `frame_err` = 0, `busy` = 0.
  - Frame FSM = WAIT_HDR; byte receiver = IDLE; synchroniser flops = 1.
- Reset may be asserted mid-byte or mid-frame. It aborts immediately with no pulses generated, and the first byte after release must pass through WAIT_HDR.
- Start-edge latency: 2 synchroniser cycles plus 1 cycle of edge detect.
- `data_valid` asserts exactly 1 clk after the tick-9 stop sample of byte 3, and `recv_data` changes on that same edge.
- `frame_err` asserts 1 clk after the failing stop sample, or in the cycle the timeout count reaches its limit.
- Back-to-back bytes with zero idle time must be received. This works because the receiver is back in IDLE about 7 ticks before the next start edge.
- `busy` rises in the cycle the FSM enters GET_B1 and falls in the cycle it returns to WAIT_HDR.
- `data_valid` and `frame_err` are never asserted in the same cycle.

## Test plan
- Send 00 11 22 33 at 115200 with no gaps → exactly one `data_valid`, `recv_data` = 0x332211, no `frame_err`, `busy` low afterwards.
- Send AA 55 00 01 02 03 → AA and 55 are ignored, then `data_valid` with `recv_data` = 0x030201.
- Send 00 00 00 00 → `data_valid` with `recv_data` = 0x000000 (0x00 bytes accepted as payload).
- Send 00 44, then hold the line idle for 25 bit periods → `frame_err` pulse at the 20th bit period. A following 00 77 88 99 gives `recv_data` = 0x998877.
- Send 00 12, then a byte with stop bit 0, then 34 56 → `frame_err` once, no `data_valid`, `recv_data` keeps its previous value.
- Apply a low glitch of 5 clk on an idle line → no byte received and no outputs change. Then assert `rst` halfway through the payload of 00 AB CD EF and release it → all outputs 0 and no `data_valid`. The next full frame is received correctly.
